// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: the buffered entry layout, the canonical NOP
// and the RV32 major opcodes that the decoders switch on.
package fetch_pkg;

  localparam int FETCH_AW = 32;
  localparam int FETCH_DW = 32;

  typedef struct packed {
    logic [FETCH_AW-1:0] pc;
    logic [FETCH_DW-1:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  function automatic logic [6:0] opcode_of(input logic [31:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a synchronous flush; head entry is read combinationally.
// Push into a full FIFO and pop from an empty one are ignored.
module sync_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [63:0]
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  entry_t                     push_data,
  input  logic                       pop,
  output entry_t                     head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  entry_t        mem [DEPTH];
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !flush && !full;
  assign do_pop  = pop && !flush && !empty;
  assign head    = mem[rd_ptr];
  assign count   = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: nothing reads it while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front end: issues PCs to a one-cycle synchronous instruction memory,
// buffers {pc, instr} pairs and hands them to decode over valid/ready.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    OP_WIDTH   = 7,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [OP_WIDTH-1:0]   out_op,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
);

  // Handshake: an entry moves to decode on a cycle where out_valid && out_ready
  // are both high; out_* hold steady while out_valid && !out_ready.

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic                  inflight;
  logic                  squash;
  logic [CW-1:0]         count;
  logic [CW:0]           credit_used;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  entry_t                push_entry;
  entry_t                head;
  logic                  unused_redirect_lsbs;

  assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

  // Buffered entries plus the outstanding response must fit: this is what
  // guarantees a returning word always has a free slot.
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign imem_req    = !rst && !redirect && (credit_used < (CW+1)'(DEPTH));
  assign imem_addr   = fetch_pc;

  assign push       = inflight && !squash;
  assign push_entry = '{pc: inflight_pc, instr: imem_rdata};
  assign pop        = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      squash      <= 1'b0;
    end else begin
      inflight <= imem_req;
      squash   <= redirect;
      if (imem_req) inflight_pc <= fetch_pc;
      if (redirect) begin
        fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      end else if (imem_req) begin
        fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
      end
    end
  end

  sync_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (fifo_empty)
  );

  // Outputs read as zero while empty so reset and flush present a clean bus.
  assign out_valid = !fifo_empty;
  assign out_instr = out_valid ? head.instr : '0;
  assign out_pc    = out_valid ? head.pc : '0;
  assign out_op    = out_instr[OP_WIDTH-1:0];

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: table-driven startup/backpressure vectors, a PC
// scoreboard for delivered entries, and hand sequences for redirect and reset.
module tb_instr_fetch_queue;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [6:0]  out_op;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_addr;

  typedef struct {
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[16];

  instr_fetch_queue #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .OP_WIDTH   (7),
    .DEPTH      (4),
    .RESET_PC   (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_op      (out_op),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] op_for(input logic [31:0] a);
    case (a[4:2])
      3'd0: return OPC_LOAD;
      3'd1: return OPC_STORE;
      3'd2: return OPC_OP;
      3'd3: return OPC_OP_IMM;
      3'd4: return OPC_BRANCH;
      3'd5: return OPC_AUIPC;
      3'd6: return OPC_LUI;
      default: return OPC_JAL;
    endcase
  endfunction

  function automatic logic [31:0] word_for(input logic [31:0] a);
    return {a[26:2], op_for(a)};
  endfunction

  // Instruction memory: one-cycle read, garbage when not requested.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= word_for(imem_addr);
    else          imem_rdata <= $urandom();
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refill(input logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < 128; i++) exp_q.push_back(base + 32'(i * 4));
  endtask

  // Observes one cycle with the current inputs applied.
  task automatic monitor();
    if (!rst) begin
      if (redirect) check("req_in_redirect", {31'b0, imem_req}, 32'd0);
      if (imem_req) begin
        check("req_addr", imem_addr, exp_addr);
        exp_addr = exp_addr + 32'd4;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          check("sb_pc", out_pc, exp_q[0]);
          check("sb_instr", out_instr, word_for(exp_q[0]));
          check("sb_op", {25'b0, out_op}, {25'b0, op_for(exp_q[0])});
          if (out_ready && !redirect) void'(exp_q.pop_front());
        end
      end
      if (redirect) begin
        exp_addr = {redirect_pc[31:2], 2'b00};
        refill(exp_addr);
      end
    end
  endtask

  task automatic drive(input logic rdy, input logic rd, input logic [31:0] rpc);
    out_ready   = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
    monitor();
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    redirect  = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_instr", out_instr, 32'd0);
    rst      = 1'b0;
    exp_addr = 32'h0;
    refill(32'h0);
  endtask

  task automatic run_until_valid(input int max, input string name);
    bit seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      if (out_valid) seen = 1;
      tick();
    end
    check(name, {31'b0, seen}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    tbl[4]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    tbl[5]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h0C};
    tbl[6]  = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h0C};
    tbl[7]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0C};
    tbl[8]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0C};
    tbl[9]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0C};
    tbl[10] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0C};
    tbl[11] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h0C};
    tbl[12] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
    tbl[13] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
    tbl[14] = '{1'b1, 1'b1, 32'h24, 1'b1, 32'h18};
    tbl[15] = '{1'b1, 1'b1, 32'h28, 1'b1, 32'h1C};

    tick();
    do_reset();

    // Startup, steady stream, backpressure fill and drain.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rdy, 1'b0, 32'h0);
      check($sformatf("vec%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].req});
      if (tbl[i].req) check($sformatf("vec%0d_addr", i), imem_addr, tbl[i].addr);
      check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].vld});
      if (tbl[i].vld) check($sformatf("vec%0d_pc", i), out_pc, tbl[i].pc);
      tick();
    end

    // Fill from reset with decode stalled: exactly DEPTH requests.
    do_reset();
    begin
      int reqs = 0;
      for (int i = 0; i < 10; i++) begin
        drive(1'b0, 1'b0, 32'h0);
        if (imem_req) reqs++;
        tick();
      end
      check("fill_req_count", 32'(reqs), 32'd4);
      check("fill_valid", {31'b0, out_valid}, 32'd1);
      check("fill_head_pc", out_pc, 32'h0);
    end

    // Asynchronous reset with a full FIFO.
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_req", {31'b0, imem_req}, 32'd0);
    tick();
    tick();
    rst      = 1'b0;
    exp_addr = 32'h0;
    refill(32'h0);
    drive(1'b1, 1'b0, 32'h0);
    check("post_rst_req", {31'b0, imem_req}, 32'd1);
    check("post_rst_addr", imem_addr, 32'h0);
    tick();
    run_until_valid(6, "post_rst_first_valid");
    drive(1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h0);
    check("rtype_pc", out_pc, 32'h8);
    check("rtype_op", {25'b0, out_op}, {25'b0, 7'b0110011});
    tick();

    // Drain of a full FIFO after stall: 0x0, 0x4, 0x8, 0xC.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      check($sformatf("drain%0d_pc", i), out_pc, 32'(i * 4));
      tick();
    end

    // Redirect with three entries queued and one response in flight.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      tick();
    end
    drive(1'b0, 1'b1, 32'h100);
    tick();
    drive(1'b1, 1'b0, 32'h0);
    check("redir_valid_drop", {31'b0, out_valid}, 32'd0);
    check("redir_req", {31'b0, imem_req}, 32'd1);
    check("redir_addr", imem_addr, 32'h100);
    tick();
    drive(1'b1, 1'b0, 32'h0);
    check("redir_stale_dropped", {31'b0, out_valid}, 32'd0);
    tick();
    run_until_valid(6, "redir_first_valid");

    // Misaligned target is word-aligned.
    drive(1'b1, 1'b1, 32'h106);
    tick();
    drive(1'b1, 1'b0, 32'h0);
    check("align_addr", imem_addr, 32'h104);
    tick();
    run_until_valid(6, "align_first_valid");

    // Redirect coinciding with a pop.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      tick();
    end
    drive(1'b1, 1'b1, 32'h200);
    check("pop_redir_valid", {31'b0, out_valid}, 32'd1);
    tick();
    drive(1'b1, 1'b0, 32'h0);
    check("pop_redir_flushed", {31'b0, out_valid}, 32'd0);
    tick();
    run_until_valid(6, "pop_redir_first_valid");
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
